// File: rtl/matrix_line_loader.sv
// Streams 16 matrix rows (8 for A, 8 for B) into the arithmetic unit operand
// registers, then holds the operands and the op select until the unit answers.
module matrix_line_loader #(
  parameter int LINE_W  = 32,
  parameter int ROWS    = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic                   line_valid,
  input  logic [LINE_W-1:0]      line_data,
  output logic                   line_ready,
  output logic [LINE_W*ROWS-1:0] matrix_a,
  output logic [LINE_W*ROWS-1:0] matrix_b,
  output logic [7:0]             readed_lines_count,
  output logic                   mult,
  output logic                   add,
  output logic                   sub,
  input  logic                   au_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int RB = $clog2(ROWS);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE, LOAD_A, LOAD_B, WAIT_AU
  } state_e;

  state_e                       state_q;
  logic [ROWS-1:0][LINE_W-1:0]  a_q, b_q;
  logic [7:0]                   cnt_q, cnt_d;
  logic [TW-1:0]                tmo_q;
  logic                         rdy_q, busy_q, done_q, err_q;
  logic                         mult_q, add_q, sub_q;
  logic                         xfer;
  logic [RB-1:0]                rsel;

  assign xfer  = line_valid && rdy_q;
  assign cnt_d = cnt_q + 8'd1;
  // Row 0 lives in the most significant slice of the packed matrix.
  assign rsel  = RB'(ROWS - 1) - cnt_q[RB-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mult_q  <= 1'b0;
      add_q   <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (op == 2'b11) begin
              err_q <= 1'b1;
            end else begin
              state_q <= LOAD_A;
              cnt_q   <= '0;
              tmo_q   <= '0;
              rdy_q   <= 1'b1;
              busy_q  <= 1'b1;
              add_q   <= (op == 2'b00);
              sub_q   <= (op == 2'b01);
              mult_q  <= (op == 2'b10);
            end
          end
        end
        LOAD_A: begin
          if (xfer) begin
            a_q[rsel] <= line_data;
            cnt_q     <= cnt_d;
            if (cnt_q == 8'(ROWS - 1))
              state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (xfer) begin
            b_q[rsel] <= line_data;
            cnt_q     <= cnt_d;
            if (cnt_q == 8'(2 * ROWS - 1)) begin
              state_q <= WAIT_AU;
              rdy_q   <= 1'b0;
              tmo_q   <= '0;
            end
          end
        end
        WAIT_AU: begin
          // A late au_ready on the final timeout cycle still wins.
          if (au_ready || tmo_q == TW'(TIMEOUT - 1)) begin
            done_q  <= au_ready;
            err_q   <= !au_ready;
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            mult_q  <= 1'b0;
            add_q   <= 1'b0;
            sub_q   <= 1'b0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign line_ready         = rdy_q;
  assign matrix_a           = a_q;
  assign matrix_b           = b_q;
  assign readed_lines_count = cnt_q;
  assign mult               = mult_q;
  assign add                = add_q;
  assign sub                = sub_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = err_q;

endmodule

// File: tb/tb_matrix_line_loader.sv
// Directed bench for matrix_line_loader: load, ordering, illegal op,
// busy start, timeout and reset abort.
module tb_matrix_line_loader;

  logic         clk = 1'b0;
  logic         reset, start, line_valid, au_ready;
  logic [1:0]   op;
  logic [31:0]  line_data;
  logic         line_ready, mult, add, sub, busy, done, error;
  logic [255:0] matrix_a, matrix_b;
  logic [7:0]   readed_lines_count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  matrix_line_loader #(
    .LINE_W(32), .ROWS(8), .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .line_valid(line_valid),
    .line_data(line_data),
    .line_ready(line_ready),
    .matrix_a(matrix_a),
    .matrix_b(matrix_b),
    .readed_lines_count(readed_lines_count),
    .mult(mult),
    .add(add),
    .sub(sub),
    .au_ready(au_ready),
    .busy(busy),
    .done(done),
    .error(error)
  );

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] o);
    start = 1'b1;
    op    = o;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      line_valid = 1'b1;
      line_data  = d;
      @(negedge clk);
    end
    line_valid = 1'b0;
  endtask

  task automatic finish_au();
    au_ready = 1'b1;
    @(negedge clk);
    au_ready = 1'b0;
    check("fin_done", 256'(done), 256'(1));
    check("fin_cnt", 256'(readed_lines_count), 256'(0));
    check("fin_busy", 256'(busy), 256'(0));
    check("fin_sel", 256'({mult, add, sub}), 256'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00;
    line_valid = 1'b0; line_data = '0; au_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_rdy", 256'(line_ready), 256'(0));
    check("rst_cnt", 256'(readed_lines_count), 256'(0));
    check("rst_ma", matrix_a, 256'(0));
    check("rst_flags", 256'({mult, add, sub, done, error}), 256'(0));
    reset = 1'b0;
    @(negedge clk);

    // add, back-to-back lines
    cmd(2'b00);
    check("t1_busy", 256'(busy), 256'(1));
    check("t1_rdy", 256'(line_ready), 256'(1));
    check("t1_cnt0", 256'(readed_lines_count), 256'(0));
    feed(32'h11111111, 8);
    check("t1_cnt8", 256'(readed_lines_count), 256'(8));
    feed(32'h22222222, 7);
    check("t1_cnt15", 256'(readed_lines_count), 256'(15));
    check("t1_rdy15", 256'(line_ready), 256'(1));
    feed(32'h22222222, 1);
    check("t1_cnt16", 256'(readed_lines_count), 256'(16));
    check("t1_rdy16", 256'(line_ready), 256'(0));
    check("t1_ma", matrix_a, {8{32'h11111111}});
    check("t1_mb", matrix_b, {8{32'h22222222}});
    check("t1_sel", 256'({mult, add, sub}), 256'(3'b010));
    repeat (2) @(negedge clk);
    check("t1_nodone", 256'(done), 256'(0));
    finish_au();
    @(negedge clk);
    check("t1_done1", 256'(done), 256'(0));

    // mult, row ordering with gaps; stale au_ready during load
    cmd(2'b10);
    for (int k = 0; k < 16; k++) begin
      line_valid = 1'b1;
      line_data  = 32'(k);
      au_ready   = 1'b0;
      @(negedge clk);
      check("t2_mult", 256'(mult), 256'(1));
      line_valid = 1'b0;
      au_ready   = (k < 15);
      @(negedge clk);
      if (k < 15)
        check("t2_busy", 256'({busy, done}), 256'(2'b10));
    end
    au_ready = 1'b0;
    check("t2_cnt", 256'(readed_lines_count), 256'(16));
    check("t2_rdy", 256'(line_ready), 256'(0));
    check("t2_a0", 256'(matrix_a[255:224]), 256'(0));
    check("t2_a7", 256'(matrix_a[31:0]), 256'(7));
    check("t2_b0", 256'(matrix_b[255:224]), 256'(8));
    check("t2_b7", 256'(matrix_b[31:0]), 256'(15));
    finish_au();

    // illegal op, then start while busy
    cmd(2'b11);
    check("t3_err", 256'(error), 256'(1));
    check("t3_busy", 256'(busy), 256'(0));
    @(negedge clk);
    check("t3_err0", 256'(error), 256'(0));
    cmd(2'b01);
    start      = 1'b1;
    op         = 2'b00;
    line_valid = 1'b1;
    line_data  = 32'hDEADBEEF;
    @(negedge clk);
    start      = 1'b0;
    line_valid = 1'b0;
    check("t3_sel", 256'({mult, add, sub}), 256'(3'b001));
    check("t3_cnt", 256'(readed_lines_count), 256'(1));
    feed(32'h5, 15);
    check("t3_cnt16", 256'(readed_lines_count), 256'(16));
    check("t3_a0", 256'(matrix_a[255:224]), 256'(32'hDEADBEEF));
    finish_au();

    // timeout
    cmd(2'b00);
    feed(32'h3, 16);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      if (error || done)
        check("t4_early", 256'({error, done}), 256'(0));
    end
    @(negedge clk);
    check("t4_err", 256'({error, done}), 256'(2'b10));
    check("t4_cnt", 256'(readed_lines_count), 256'(0));
    check("t4_sel", 256'({mult, add, sub, busy}), 256'(0));

    // reset mid-load
    cmd(2'b10);
    feed(32'h7, 5);
    check("t5_cnt5", 256'(readed_lines_count), 256'(5));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_ma", matrix_a, 256'(0));
    check("t5_mb", matrix_b, 256'(0));
    check("t5_flags",
          256'({line_ready, busy, mult, add, sub, done, error}), 256'(0));
    check("t5_cnt", 256'(readed_lines_count), 256'(0));
    cmd(2'b00);
    feed(32'hA, 16);
    check("t5_cnt16", 256'(readed_lines_count), 256'(16));
    check("t5_add", 256'(add), 256'(1));
    finish_au();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
